// File: rtl/vmx_pkg.sv
// Shared definitions for the VMX result collector: default array geometry and
// the collector state encoding.
package vmx_pkg;

  localparam int unsigned SIZE           = 4;
  localparam int unsigned PRODUCT_BITLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FLUSH
  } collector_state_e;

endpackage

// File: rtl/vmx_result_collector_if.sv
// Handshake bundle between the PE array edge, the collector and the row consumer.
interface vmx_result_collector_if #(
  parameter int unsigned SIZE           = vmx_pkg::SIZE,
  parameter int unsigned PRODUCT_BITLEN = vmx_pkg::PRODUCT_BITLEN
);

  logic                           in_valid;
  logic                           in_ready;
  logic                           simd_mode;
  logic [SIZE*PRODUCT_BITLEN-1:0] product_in;
  logic                           out_valid;
  logic                           out_ready;
  logic [SIZE*PRODUCT_BITLEN-1:0] out_data;
  logic                           out_simd;

  modport master (
    output in_valid, simd_mode, product_in, out_ready,
    input  in_ready, out_valid, out_data, out_simd
  );

  modport slave (
    input  in_valid, simd_mode, product_in, out_ready,
    output in_ready, out_valid, out_data, out_simd
  );

endinterface

// File: rtl/vmx_sync_fifo.sv
// Synchronous FIFO with explicit occupancy count; pointers wrap modulo DEPTH and
// the count separates full from empty. A write while full is taken only with a read.
module vmx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  import vmx_pkg::*;

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = wr_en && (!full || rd_en);
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= next_ptr(wr_ptr);
      if (rd_fire) rd_ptr <= next_ptr(rd_ptr);
      unique case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vmx_result_collector.sv
// De-skews PE-array edge products into aligned rows and buffers them for a
// valid/ready consumer. Optional per-lane ReLU clamp: define VMX_COLLECT_RELU_EN.
module vmx_result_collector #(
  parameter int unsigned SIZE           = vmx_pkg::SIZE,
  parameter int unsigned PRODUCT_BITLEN = vmx_pkg::PRODUCT_BITLEN,
  parameter int unsigned BASE_LAT       = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  vmx_result_collector_if.slave  bus,
  input  logic                   flush,
  output logic                   busy,
  output logic                   overflow
);
  import vmx_pkg::*;

  localparam int unsigned TAG_LEN = BASE_LAT + SIZE - 1;
  localparam int unsigned ROW_W   = SIZE * PRODUCT_BITLEN;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  collector_state_e   state;
  collector_state_e   state_next;

  logic [TAG_LEN-1:0] tag_valid;
  logic [TAG_LEN-1:0] tag_simd;
  logic [TAG_LEN-1:0] tag_valid_next;
  logic [TAG_LEN-1:0] tag_simd_next;
  int unsigned        inflight;
  int unsigned        inflight_next;
  int unsigned        fifo_count_next;

  logic               accept;
  logic               push;
  logic               pop;
  logic [ROW_W-1:0]   row_push;
  logic [ROW_W:0]     fifo_rd;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  function automatic int unsigned ones(input logic [TAG_LEN-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < TAG_LEN; k++) begin
      if (v[k]) n = n + 1;
    end
    return n;
  endfunction

`ifdef VMX_COLLECT_RELU_EN
  // In SIMD mode each 16-bit half carries its own sign and is clamped alone.
  function automatic logic [PRODUCT_BITLEN-1:0] relu(input logic [PRODUCT_BITLEN-1:0] v,
                                                     input logic simd);
    logic [PRODUCT_BITLEN-1:0] r;
    r = v;
    if (simd) begin
      for (int unsigned h = 0; h < PRODUCT_BITLEN / 16; h++) begin
        if (v[h*16 + 15]) r[h*16 +: 16] = '0;
      end
    end else if (v[PRODUCT_BITLEN-1]) begin
      r = '0;
    end
    return r;
  endfunction
`endif

  // Lane i lands i cycles after lane 0, so it waits SIZE-1-i cycles; the last
  // lane is taken straight from the array edge at the push edge.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    localparam int unsigned DLY = SIZE - 1 - i;
    logic [PRODUCT_BITLEN-1:0] lane_in;
    logic [PRODUCT_BITLEN-1:0] lane_aligned;

    assign lane_in = bus.product_in[i*PRODUCT_BITLEN +: PRODUCT_BITLEN];

    if (DLY == 0) begin : g_direct
      assign lane_aligned = lane_in;
    end else begin : g_delay
      logic [PRODUCT_BITLEN-1:0] dly [DLY];
      always_ff @(posedge clk) begin
        dly[0] <= lane_in;
        for (int unsigned k = 1; k < DLY; k++) dly[k] <= dly[k-1];
      end
      assign lane_aligned = dly[DLY-1];
    end

`ifdef VMX_COLLECT_RELU_EN
    assign row_push[i*PRODUCT_BITLEN +: PRODUCT_BITLEN] = relu(lane_aligned, tag_simd[TAG_LEN-1]);
`else
    assign row_push[i*PRODUCT_BITLEN +: PRODUCT_BITLEN] = lane_aligned;
`endif
  end

  // Admission reserves a FIFO slot for every vector still travelling in the tag line.
  assign bus.in_ready  = !fifo_full && (32'(fifo_count) + inflight < FIFO_DEPTH) && (state != FLUSH);
  assign accept        = bus.in_valid && bus.in_ready && !flush;
  assign push          = tag_valid[TAG_LEN-1] && !flush;
  assign bus.out_valid = !fifo_empty && (state != FLUSH);
  assign pop           = bus.out_valid && bus.out_ready && !flush;
  assign bus.out_data  = bus.out_valid ? fifo_rd[ROW_W-1:0] : '0;
  assign bus.out_simd  = bus.out_valid && fifo_rd[ROW_W];
  assign busy          = (state == BUSY);

  always_comb begin
    tag_valid_next = '0;
    tag_simd_next  = '0;
    if (!flush) begin
      tag_valid_next[0] = accept;
      tag_simd_next[0]  = accept && bus.simd_mode;
      for (int unsigned k = 1; k < TAG_LEN; k++) begin
        tag_valid_next[k] = tag_valid[k-1];
        tag_simd_next[k]  = tag_simd[k-1];
      end
    end
  end

  always_comb begin
    inflight        = ones(tag_valid);
    inflight_next   = ones(tag_valid_next);
    fifo_count_next = flush ? 0 : 32'(fifo_count) + 32'(push) - 32'(pop);
  end

  // State tracks the occupancy that will exist after this edge, so busy
  // matches the registered tag line and FIFO without a cycle of lag.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FLUSH;
    end else if (state == FLUSH) begin
      state_next = IDLE;
    end else if (inflight_next != 0 || fifo_count_next != 0) begin
      state_next = BUSY;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tag_valid <= '0;
      tag_simd  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      tag_valid <= tag_valid_next;
      tag_simd  <= tag_simd_next;
      if (bus.in_valid && !bus.in_ready) overflow <= 1'b1;
    end
  end

  vmx_sync_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .wr_en   (push),
    .wr_data ({tag_simd[TAG_LEN-1], row_push}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_vmx_result_collector.sv
// Directed, table-driven bench for vmx_result_collector at default geometry.
module tb_vmx_result_collector;

  localparam int SZ = 4;
  localparam int PB = 32;
  localparam int BL = 4;
  localparam int LATE = BL + SZ - 1;   // edges from accept edge to push edge

  typedef struct packed {
    logic         simd;
    logic [127:0] data;
    logic [127:0] plain;
    logic [127:0] relu;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  logic overflow;

  always #5 clk = ~clk;

  vmx_result_collector_if #(.SIZE(SZ), .PRODUCT_BITLEN(PB)) bus ();

  vmx_result_collector #(
    .SIZE           (SZ),
    .PRODUCT_BITLEN (PB),
    .BASE_LAT       (BL),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .busy     (busy),
    .overflow (overflow)
  );

  vec_t vt [6];
  int   acc_vec [0:1023];
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  function automatic logic [127:0] row_of(input int id);
`ifdef VMX_COLLECT_RELU_EN
    return vt[id].relu;
`else
    return vt[id].plain;
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  // Present each lane of a scheduled vector BASE_LAT+i cycles after its accept.
  task automatic drive_lanes();
    for (int i = 0; i < SZ; i++) begin
      int e;
      e = cyc + 1 - BL - i;
      if (e >= 0 && acc_vec[e] >= 0)
        bus.product_in[i*PB +: PB] = vt[acc_vec[e]].data[i*PB +: PB];
      else
        bus.product_in[i*PB +: PB] = 32'hEE00_0000 | 32'(cyc);
    end
  endtask

  // Free-flowing output model: row accepted at edge E is visible after edge E+LATE.
  task automatic monitor();
    int e;
    logic expv;
    e = cyc - LATE;
    expv = (e >= 0) && (acc_vec[e] >= 0);
    chk1("mon_out_valid", bus.out_valid, expv);
    if (expv) begin
      chk("mon_out_data", bus.out_data, row_of(acc_vec[e]));
      chk1("mon_out_simd", bus.out_simd, vt[acc_vec[e]].simd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive_lanes();
    if (mon_en) monitor();
  endtask

  task automatic issue(input int id);
    bus.in_valid  = 1'b1;
    bus.simd_mode = vt[id].simd;
    acc_vec[cyc + 1] = id;
    step();
    bus.in_valid  = 1'b0;
    bus.simd_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100},
                    {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100},
                    {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100}};
    vt[1] = '{1'b0, {32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0},
                    {32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0},
                    {32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000}};
    vt[2] = '{1'b1, {32'h1234_5678, 32'hFFFF_FFFF, 32'h0005_8001, 32'h8001_0005},
                    {32'h1234_5678, 32'hFFFF_FFFF, 32'h0005_8001, 32'h8001_0005},
                    {32'h1234_5678, 32'h0000_0000, 32'h0005_0000, 32'h0000_0005}};
    vt[3] = '{1'b1, {32'hFFFF_0001, 32'h0000_0000, 32'h8000_8000, 32'h7FFF_7FFF},
                    {32'hFFFF_0001, 32'h0000_0000, 32'h8000_8000, 32'h7FFF_7FFF},
                    {32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_7FFF}};
    vt[4] = '{1'b0, {32'h89AB_CDEF, 32'h0123_4567, 32'hCAFE_F00D, 32'hDEAD_BEEF},
                    {32'h89AB_CDEF, 32'h0123_4567, 32'hCAFE_F00D, 32'hDEAD_BEEF},
                    {32'h0000_0000, 32'h0123_4567, 32'h0000_0000, 32'h0000_0000}};
    vt[5] = '{1'b1, {32'h8000_7FFF, 32'h7FFF_8000, 32'h1111_2222, 32'h0000_0000},
                    {32'h8000_7FFF, 32'h7FFF_8000, 32'h1111_2222, 32'h0000_0000},
                    {32'h0000_7FFF, 32'h7FFF_0000, 32'h1111_2222, 32'h0000_0000}};
    for (int i = 0; i < 1024; i++) acc_vec[i] = -1;
    cyc = 0; checks = 0; errors = 0; mon_en = 1'b0;

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.simd_mode = 1'b0;
    bus.out_ready = 1'b1;
    bus.product_in = '0;

    // Reset state
    step();
    step();
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk1("rst_out_simd", bus.out_simd, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    rst = 1'b0;

    // Single vector, latency BASE_LAT+SIZE
    mon_en = 1'b1;
    step();
    chk1("single_in_ready", bus.in_ready, 1'b1);
    issue(0);
    chk1("single_busy", busy, 1'b1);
    repeat (10) step();
    chk1("single_idle", busy, 1'b0);

    // Table: back-to-back batches of four, consumer always ready
    for (int k = 0; k < 6; k++) begin
      if (k == 4) repeat (12) step();
      chk1("b2b_in_ready", bus.in_ready, 1'b1);
      issue(k);
      if (k == 3) chk1("b2b_reserve_full", bus.in_ready, 1'b0);
    end
    repeat (12) step();
    chk1("b2b_idle", busy, 1'b0);
    mon_en = 1'b0;

    // Backpressure: four accepts, fifth rejected, head row held stable
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("bp_in_ready", bus.in_ready, 1'b1);
      issue(k);
    end
    chk1("bp_in_ready_low", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk1("bp_overflow", overflow, 1'b1);
    repeat (3) step();
    chk1("bp_first_valid", bus.out_valid, 1'b1);
    chk("bp_first_data", bus.out_data, row_of(0));
    repeat (3) step();
    chk("bp_hold_data", bus.out_data, row_of(0));
    chk1("bp_hold_valid", bus.out_valid, 1'b1);
    chk1("bp_full_in_ready", bus.in_ready, 1'b0);
    chk1("bp_busy", busy, 1'b1);

    // Pop one, refill through the array, then push and pop on the same edge
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pp_after_pop", bus.out_data, row_of(1));
    chk1("pp_slot_free", bus.in_ready, 1'b1);
    issue(4);
    chk1("pp_reserved", bus.in_ready, 1'b0);
    repeat (LATE - 1) step();
    chk("pp_hold", bus.out_data, row_of(1));
    bus.out_ready = 1'b1;
    step();
    chk1("pp_valid", bus.out_valid, 1'b1);
    chk("pp_row2", bus.out_data, row_of(2));
    chk1("pp_count_kept", bus.in_ready, 1'b1);
    step();
    chk("pp_row3", bus.out_data, row_of(3));
    step();
    chk("pp_row4", bus.out_data, row_of(4));
    chk1("pp_row4_simd", bus.out_simd, vt[4].simd);
    step();
    chk1("pp_drained", bus.out_valid, 1'b0);
    chk1("pp_idle", busy, 1'b0);
    chk1("overflow_sticky", overflow, 1'b1);

    // Flush with two rows buffered and two still in the tag line
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) issue(k);
    repeat (5) step();
    chk1("fl_pre_valid", bus.out_valid, 1'b1);
    chk("fl_pre_data", bus.out_data, row_of(0));
    flush = 1'b1;
    step();
    chk1("fl_out_valid", bus.out_valid, 1'b0);
    chk1("fl_in_ready", bus.in_ready, 1'b0);
    chk1("fl_busy", busy, 1'b0);
    flush = 1'b0;
    step();
    chk1("fl_rel_busy", busy, 1'b0);
    chk1("fl_rel_in_ready", bus.in_ready, 1'b1);
    chk1("fl_rel_out_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk1("fl_no_stale", bus.out_valid, 1'b0);
    end

    // Asynchronous reset in the middle of traffic
    issue(2);
    issue(3);
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    chk1("mr_out_valid", bus.out_valid, 1'b0);
    chk1("mr_busy", busy, 1'b0);
    chk1("mr_in_ready", bus.in_ready, 1'b1);
    chk1("mr_overflow", overflow, 1'b0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk1("mr_no_partial", bus.out_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
